// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - read side and status pulses of the PS/2 receive FIFO
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rd_en;
    logic [9:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             parity_err;
    logic             frame_err;
    logic             overflow;

    // receiver side: produces entries and status
    modport master (
        input  rd_en,
        output rd_data, empty, full, count, parity_err, frame_err, overflow
    );

    // consumer side: pops entries and watches status
    modport slave (
        output rd_en,
        input  rd_data, empty, full, count, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - filtered PS/2 deframer with prefix merge and result FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 8,
    parameter int DECODE      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2clk,
    input  logic          ps2data,
    ps2_rx_fifo_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FLT_W = $clog2(FILTER_LEN);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam bit DEC   = (DECODE != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             filt_q, filt_d, filt_dly_q, data_filt_q, data_filt_d;
    logic             fall;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             ext_q, ext_d, brk_q, brk_d;
    logic             push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [9:0]       push_data_q, push_data_d;

    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             perr_out_q, ferr_out_q, ovf_q, ovf_d;
    logic             full, empty, do_push, do_pop;

    // two-stage synchronisers, idle line level out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // clock follows the synchronised line only after FILTER_LEN equal samples;
    // data is captured on that same cycle so it stays aligned with the filtered clock
    always_comb begin
        flt_cnt_d   = '0;
        filt_d      = filt_q;
        data_filt_d = data_filt_q;
        if (clk_sync_q != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d      = clk_sync_q;
                data_filt_d = dat_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // filter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_cnt_q   <= '0;
            filt_q      <= 1'b1;
            filt_dly_q  <= 1'b1;
            data_filt_q <= 1'b1;
        end else begin
            flt_cnt_q   <= flt_cnt_d;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_q;
            data_filt_q <= data_filt_d;
        end
    end

    assign fall = filt_dly_q & ~filt_q;

    // frame deframing, watchdog and prefix merge; results leave as registered strobes
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        wd_d        = wd_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        if (fall) begin
            wd_d = '0;
            case (state_q)
                IDLE: begin
                    if (data_filt_q) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_filt_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_filt_q) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (!((^shift_q) ^ par_q)) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (DEC && shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (DEC && shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        push_d      = 1'b1;
                        push_data_d = DEC ? {ext_q, brk_q, shift_q} : {2'b00, shift_q};
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                ferr_d  = 1'b1;
                state_d = IDLE;
                wd_d    = '0;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
    end

    // frame FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = bus.rd_en & ~empty;
    assign do_push = push_q & (~full | do_pop);

    // pointer and occupancy bookkeeping; a pop frees the slot a full-FIFO push lands in
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_q & full & ~do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // FIFO control and error pulses, aligned with the cycle the push lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_q;
        end
    end

    // storage array, contents only meaningful below count
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign bus.rd_data    = empty ? 10'h000 : mem_q[rd_ptr_q];
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.parity_err = perr_out_q;
    assign bus.frame_err  = ferr_out_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed vector bench for ps2_rx_fifo in decode and raw modes
module tb_ps2_rx_fifo;
    localparam int L    = 8;
    localparam int TMO  = 300;
    localparam int HALF = 25;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2clk_a = 1'b1, ps2data_a = 1'b1;
    logic ps2clk_b = 1'b1, ps2data_b = 1'b1;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(8)) bus_a ();
    ps2_rx_fifo_if #(.FIFO_DEPTH(4)) bus_b ();

    ps2_rx_fifo #(.FILTER_LEN(L), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(8), .DECODE(1)) u_dec (
        .clk(clk), .reset(reset), .ps2clk(ps2clk_a), .ps2data(ps2data_a), .bus(bus_a)
    );
    ps2_rx_fifo #(.FILTER_LEN(L), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4), .DECODE(0)) u_raw (
        .clk(clk), .reset(reset), .ps2clk(ps2clk_b), .ps2data(ps2data_b), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int perr_a = 0, ferr_a = 0, ovf_b = 0, ferr_b = 0, perr_b = 0;
    int lat_cnt, lat_perr, lat_ferr, lat_ovf;

    always @(negedge clk) begin
        if (bus_a.parity_err) perr_a <= perr_a + 1;
        if (bus_a.frame_err)  ferr_a <= ferr_a + 1;
        if (bus_b.parity_err) perr_b <= perr_b + 1;
        if (bus_b.frame_err)  ferr_b <= ferr_b + 1;
        if (bus_b.overflow)   ovf_b  <= ovf_b + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_count(input int sel);
        return (sel == 0) ? int'(bus_a.count) : int'(bus_b.count);
    endfunction
    function automatic int get_rdata(input int sel);
        return (sel == 0) ? int'(bus_a.rd_data) : int'(bus_b.rd_data);
    endfunction
    function automatic int get_empty(input int sel);
        return (sel == 0) ? int'(bus_a.empty) : int'(bus_b.empty);
    endfunction
    function automatic int get_full(input int sel);
        return (sel == 0) ? int'(bus_a.full) : int'(bus_b.full);
    endfunction

    task automatic set_rd(input int sel, input logic v);
        if (sel == 0) bus_a.rd_en = v; else bus_b.rd_en = v;
    endtask
    task automatic set_clk(input int sel, input logic v);
        if (sel == 0) ps2clk_a = v; else ps2clk_b = v;
    endtask
    task automatic set_dat(input int sel, input logic v);
        if (sel == 0) ps2data_a = v; else ps2data_b = v;
    endtask

    // Sends the first nbits of a frame; after the last falling edge it records the
    // cycle on which count changes and each status pulse first appears (0 = never).
    task automatic send_frame(input int sel, input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input bit bad_start, input int nbits,
                              input bit pop_at_push);
        logic [10:0] f;
        int c0;
        f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        lat_cnt = 0; lat_perr = 0; lat_ferr = 0; lat_ovf = 0;
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            set_dat(sel, f[i]);
            repeat (HALF) @(posedge clk);
            #1 set_clk(sel, 1'b0);
            if (i == nbits - 1) begin
                c0 = get_count(sel);
                for (int n = 1; n <= 20; n++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (lat_cnt == 0 && get_count(sel) != c0) lat_cnt = n;
                    if (lat_perr == 0 && ((sel == 0) ? bus_a.parity_err : bus_b.parity_err)) lat_perr = n;
                    if (lat_ferr == 0 && ((sel == 0) ? bus_a.frame_err : bus_b.frame_err)) lat_ferr = n;
                    if (lat_ovf == 0 && ((sel == 0) ? bus_a.overflow : bus_b.overflow)) lat_ovf = n;
                    if (pop_at_push && n == L + 3) set_rd(sel, 1'b1);
                    if (pop_at_push && n == L + 4) set_rd(sel, 1'b0);
                end
                @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 set_clk(sel, 1'b1);
        end
    endtask

    task automatic pop_check(input int sel, input int exp, input string name);
        @(negedge clk);
        check({name, "_rd_data"}, get_rdata(sel), exp);
        check({name, "_not_empty"}, get_empty(sel), 0);
        @(posedge clk); #1 set_rd(sel, 1'b1);
        @(posedge clk); #1 set_rd(sel, 1'b0);
    endtask

    task automatic glitch(input int sel);
        @(posedge clk); #1 set_clk(sel, 1'b0);
        repeat (3) @(posedge clk);
        #1 set_clk(sel, 1'b1);
        repeat (20) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_push;
        logic [9:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] rb[5];

    initial begin
        int pa, fa, ob, n;
        vecs[0]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[1]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h11C, 1'b0, 1'b0};
        vecs[2]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h375, 1'b0, 1'b0};
        vecs[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h075, 1'b0, 1'b0};
        vecs[6]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0};
        vecs[7]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[9]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[10] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[12] = '{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[13] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0, 1'b0};
        vecs[14] = '{8'hAA, 1'b0, 1'b0, 1'b1, 10'h0AA, 1'b0, 1'b0};
        rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44; rb[4] = 8'h55;

        bus_a.rd_en = 1'b0;
        bus_b.rd_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_empty_a", int'(bus_a.empty), 1);
        check("rst_full_a", int'(bus_a.full), 0);
        check("rst_count_a", int'(bus_a.count), 0);
        check("rst_rdata_a", int'(bus_a.rd_data), 0);
        check("rst_empty_b", int'(bus_b.empty), 1);
        check("rst_count_b", int'(bus_b.count), 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);

        // decode-mode vector table
        foreach (vecs[i]) begin
            pa = perr_a; fa = ferr_a;
            send_frame(0, vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, 1'b0, 11, 1'b0);
            check($sformatf("v%0d_push_lat", i), lat_cnt, vecs[i].exp_push ? L + 4 : 0);
            check($sformatf("v%0d_perr_lat", i), lat_perr, vecs[i].exp_perr ? L + 4 : 0);
            check($sformatf("v%0d_ferr_lat", i), lat_ferr, vecs[i].exp_ferr ? L + 4 : 0);
            check($sformatf("v%0d_perr_cnt", i), perr_a - pa, int'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr_cnt", i), ferr_a - fa, int'(vecs[i].exp_ferr));
            if (vecs[i].exp_push) pop_check(0, int'(vecs[i].exp_data), $sformatf("v%0d", i));
            @(negedge clk);
            check($sformatf("v%0d_empty", i), int'(bus_a.empty), 1);
        end

        // start bit sampled as 1 in IDLE, and it drops a pending E0
        send_frame(0, 8'hE0, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        check("bad_start_ferr_lat", lat_ferr, L + 4);
        check("bad_start_no_push", lat_cnt, 0);
        send_frame(0, 8'h1C, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        pop_check(0, 10'h01C, "after_bad_start");

        // stalled frame recovered by the watchdog
        fa = ferr_a;
        send_frame(0, 8'h1C, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        check("stall_no_early_ferr", ferr_a - fa, 0);
        n = 0;
        while (ferr_a == fa && n < TMO + 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_ferr", ferr_a - fa, 1);
        check("timeout_window", (n >= TMO - 20 && n <= TMO) ? 1 : 0, 1);
        check("timeout_count", int'(bus_a.count), 0);
        send_frame(0, 8'h1C, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        check("after_timeout_lat", lat_cnt, L + 4);
        pop_check(0, 10'h01C, "after_timeout");

        // raw mode: fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            send_frame(1, rb[i], 1'b0, 1'b0, 1'b0, 11, 1'b0);
            check($sformatf("raw_fill%0d_count", i), int'(bus_b.count), i + 1);
        end
        ob = ovf_b;
        send_frame(1, rb[4], 1'b0, 1'b0, 1'b0, 11, 1'b0);
        check("raw_ovf_lat", lat_ovf, L + 4);
        check("raw_ovf_no_count", lat_cnt, 0);
        check("raw_ovf_pulses", ovf_b - ob, 1);
        check("raw_full", int'(bus_b.full), 1);
        check("raw_count4", int'(bus_b.count), 4);
        for (int i = 0; i < 4; i++) pop_check(1, {2'b00, rb[i]}, $sformatf("raw_rd%0d", i));
        @(negedge clk);
        check("raw_drained", int'(bus_b.empty), 1);

        // raw mode: pop coinciding with the push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(1, rb[i], 1'b0, 1'b0, 1'b0, 11, 1'b0);
        ob = ovf_b;
        send_frame(1, rb[4], 1'b0, 1'b0, 1'b0, 11, 1'b1);
        check("pp_count_held", lat_cnt, 0);
        check("pp_no_ovf", ovf_b - ob, 0);
        check("pp_count4", int'(bus_b.count), 4);
        check("pp_full", int'(bus_b.full), 1);
        for (int i = 1; i < 5; i++) pop_check(1, {2'b00, rb[i]}, $sformatf("pp_rd%0d", i));
        @(negedge clk);
        check("pp_drained", int'(bus_b.empty), 1);
        check("raw_no_errs", perr_b + ferr_b, 0);

        // reset in the middle of a frame with an entry already queued
        send_frame(0, 8'h2D, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        check("pre_rst_count", int'(bus_a.count), 1);
        send_frame(0, 8'h1C, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        pa = perr_a; fa = ferr_a;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_empty", int'(bus_a.empty), 1);
        check("mid_rst_full", int'(bus_a.full), 0);
        check("mid_rst_count", int'(bus_a.count), 0);
        check("mid_rst_rdata", int'(bus_a.rd_data), 0);
        check("mid_rst_pulses", int'(bus_a.parity_err) + int'(bus_a.frame_err) + int'(bus_a.overflow), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (TMO + 50) @(posedge clk);
        glitch(0);
        glitch(0);
        glitch(0);
        @(negedge clk);
        check("post_rst_no_errs", (ferr_a - fa) + (perr_a - pa), 0);
        check("post_rst_count", int'(bus_a.count), 0);
        send_frame(0, 8'h1C, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        check("post_rst_lat", lat_cnt, L + 4);
        check("post_rst_single", int'(bus_a.count), 1);
        pop_check(0, 10'h01C, "post_rst");
        @(negedge clk);
        check("post_rst_empty", int'(bus_a.empty), 1);
        check("post_rst_errs_final", (ferr_a - fa) + (perr_a - pa), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that replaces the single-byte keyboard front end feeding the keyboard controller in the top level. It filters and synchronises the raw `ps2clk`/`ps2data` lines, deframes 11-bit PS/2 frames, and checks parity, start and stop bits. A watchdog recovers it from stalled frames. It can optionally merge `E0`/`F0` prefixes into tagged key events, and it buffers results in a FIFO so the consumer can read at its own pace.

## Interface
- `FILTER_LEN`, default 8: consecutive identical `clk` samples required before the filtered `ps2clk` changes (2..255).
- `TIMEOUT_CYC`, default 200000: `clk` cycles without a `ps2clk` falling edge before an in-progress frame is aborted (2 ms at 100 MHz).
- `FIFO_DEPTH`, default 8: entries, power of two, 2..64.
- `DECODE`, default 1: 0 = raw mode, every byte stored; 1 = prefix-merge mode.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `ps2clk` in 1: raw keyboard clock, asynchronous.
- `ps2data` in 1: raw keyboard data, asynchronous.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `rd_data` out 10: head entry `{ext, brk, code[7:0]}`, valid while `!empty`, show-ahead.
- `empty` out 1: FIFO has no entries.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `count` out $clog2(FIFO_DEPTH)+1: current number of entries.
- `parity_err` out 1: one-cycle pulse, frame failed the odd-parity check.
- `frame_err` out 1: one-cycle pulse, bad start bit, bad stop bit, or timeout.
- `overflow` out 1: one-cycle pulse, a result was dropped because the FIFO was full.

## Operation
- **Input conditioning**
  - Both lines pass through 2-FF synchronisers.
  - The `ps2clk` filter is a counter. The filtered clock takes the synchronised value after `FILTER_LEN` consecutive equal samples.
  - `ps2data` is delayed to stay aligned with the filtered clock.
  - One sample is taken per filtered falling edge.
- **Frame FSM states**: IDLE, DATA, PARITY, STOP.
  - IDLE: sample 0 -> DATA with bit counter = 0. Sample 1 -> `frame_err` pulse, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: stop = 1 and XOR(data, parity) = 1 -> byte accepted. Stop = 0 -> `frame_err`. Parity wrong (with stop = 1) -> `parity_err`. If both fail, only `frame_err` is raised. Always return to IDLE.
- **Watchdog**
  - Cleared on every filtered falling edge; runs only outside IDLE.
  - Reaching `TIMEOUT_CYC` -> `frame_err` pulse, FSM to IDLE, partial byte discarded.
- **Decode, `DECODE`=1**
  - `E0` sets the `ext` flag; `F0` sets the `brk` flag. Neither is pushed.
  - Any other byte pushes `{ext, brk, byte}`, then clears both flags.
  - Any error or timeout clears both flags.
- **Raw mode, `DECODE`=0**: every accepted byte pushes `{2'b00, byte}`.
- **FIFO**
  - Circular buffer with read and write pointers; `count` is kept explicitly.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. This also applies when full.
  - Push when full without a pop: entry dropped, `overflow` pulse, contents unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset (`reset` = 0)**: applies at any time, including mid-frame.
  - FSM goes to IDLE; flags, watchdog, pointers and `count` are cleared.
  - Synchroniser and filter outputs go to 1 (the idle line level).
  - Outputs: `empty`=1, `full`=0, `count`=0, `rd_data`=0, all error pulses 0.

## Timing
- Push latency: `empty` falls, or `count` increments, exactly `FILTER_LEN`+4 `clk` cycles after the raw `ps2clk` falling edge of the stop bit. This is fixed and verified.
- Error pulses assert in the same cycle the push would have occurred.
- `rd_data` changes one cycle after a popping `rd_en`, on the same edge that updates `count`.
- Glitches on `ps2clk` shorter than `FILTER_LEN` cycles have no effect.
- PS/2 bit period is 60–100 µs, well above `TIMEOUT_CYC` granularity. A frame must complete within 11 × `TIMEOUT_CYC` cycles with no gap exceeding `TIMEOUT_CYC`.

## Test plan
- `DECODE`=1: send `F0` (parity 1) then `1C` (parity 0). Expect exactly one entry, `rd_data`=0x11C, no errors.
- `DECODE`=1: send `E0`, `F0`, `75`. Expect one entry 0x375. A following `75` alone gives 0x075.
- Send `1C` with parity bit 1. Expect a `parity_err` pulse, FIFO empty. A following correct `1C` gives entry 0x01C.
- Send 5 bits then stall longer than `TIMEOUT_CYC`. Expect a `frame_err` pulse and FSM in IDLE. A subsequent valid `1C` gives entry 0x01C.
- `DECODE`=0, `FIFO_DEPTH`=4: send `11`, `22`, `33`, `44`, `55` with no reads.
  - Expect `full`=1 and one `overflow` pulse.
  - Reads return 0x011, 0x022, 0x033, 0x044, then `empty`=1.
  - Repeat with `rd_en` held during the 5th push. Nothing is dropped and `count` stays 4.
- Assert `reset` low mid-frame (after bit 3), release it, then send `1C`. Expect all outputs at reset values during reset, no error pulse, and a single entry 0x01C. Also inject 3-cycle `ps2clk` glitches; expect no effect.
